// File: rtl/i2c_bit_engine.sv
// I2C master bit engine: turns START/STOP/WRITE/READ commands into open-drain
// SCL/SDA drive using a four-phase (A,B,C,D) bit slot with clock stretching.
module i2c_bit_engine #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_nack_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_nack_o,
  output logic       rsp_err_o,
  output logic       busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o
);

  localparam logic [15:0] DivM1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] DivM2  = 16'(CLK_DIV - 2);
  localparam bit          DivOne = (CLK_DIV == 1);

  localparam logic [1:0] CmdStart = 2'b00;
  localparam logic [1:0] CmdStop  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;
  localparam logic [1:0] CmdRead  = 2'b11;

  localparam logic [1:0] PhA = 2'd0;
  localparam logic [1:0] PhB = 2'd1;
  localparam logic [1:0] PhC = 2'd2;
  localparam logic [1:0] PhD = 2'd3;

  typedef enum logic [2:0] {StIdle, StStart, StStop, StData, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_phase, w_phase_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [3:0]  r_slot, w_slot_d;
  logic [1:0]  r_cmd;
  logic [7:0]  r_tx, r_rx, r_rsp_data;
  logic        r_nack_cmd, r_illegal, r_ack, r_busy;
  logic        r_rsp_nack, r_rsp_err, r_scl_hold, r_sda_hold;

  logic w_accept, w_illegal, w_active, w_stall, w_phase_end, w_last_slot;
  logic w_sample, w_finish, w_ack, w_scl, w_sda;

  // Phase timing, stretch detection and command-completion decode
  always_comb begin
    w_accept    = (r_state == StIdle) && cmd_valid_i;
    w_illegal   = (cmd_i != CmdStart) && !r_busy;
    w_active    = (r_state == StStart) || (r_state == StStop) || (r_state == StData);
    // Phase B does not begin counting until the slave lets SCL go high
    w_stall     = (r_phase == PhB) && (r_cnt == 16'd0) && !scl_i;
    w_phase_end = !w_stall && (r_cnt == DivM1);
    w_last_slot = (r_state != StData) || (r_slot == 4'd8);
    w_sample    = (r_state == StData) && (r_phase == PhC) && w_phase_end;
    // The DONE cycle stands in for the final cycle of the last phase D
    w_finish    = w_active && w_last_slot &&
                  (DivOne ? ((r_phase == PhC) && w_phase_end)
                          : ((r_phase == PhD) && (r_cnt == DivM2)));
    w_ack       = w_sample ? sda_i : r_ack;
  end

  // Next-state logic for the command sequencer
  always_comb begin
    w_state_d = r_state;
    w_phase_d = r_phase;
    w_cnt_d   = r_cnt;
    w_slot_d  = r_slot;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_phase_d = PhA;
          w_cnt_d   = 16'd0;
          w_slot_d  = 4'd0;
          if (w_illegal)              w_state_d = StDone;
          else if (cmd_i == CmdStart) w_state_d = StStart;
          else if (cmd_i == CmdStop)  w_state_d = StStop;
          else                        w_state_d = StData;
        end
      end
      StStart, StStop, StData: begin
        if (w_finish) begin
          w_state_d = StDone;
          w_phase_d = PhD;
          w_cnt_d   = 16'd0;
        end else if (w_phase_end) begin
          w_cnt_d   = 16'd0;
          w_phase_d = r_phase + 2'd1;
          if (r_phase == PhD) w_slot_d = r_slot + 4'd1;
        end else if (!w_stall) begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Line drive per command and phase; idle and illegal commands hold the lines
  always_comb begin
    w_scl = r_scl_hold;
    w_sda = r_sda_hold;
    if (w_active || ((r_state == StDone) && !r_illegal)) begin
      unique case (r_cmd)
        CmdStart: begin
          w_scl = (r_phase == PhA) ? r_busy : (r_phase == PhD);
          w_sda = (r_phase == PhC) || (r_phase == PhD);
        end
        CmdStop: begin
          w_scl = (r_phase == PhA);
          w_sda = (r_phase == PhA) || (r_phase == PhB);
        end
        default: begin
          w_scl = (r_phase == PhA) || (r_phase == PhD);
          if (r_slot == 4'd8) w_sda = (r_cmd == CmdRead) && !r_nack_cmd;
          else                w_sda = (r_cmd == CmdWrite) && !r_tx[7];
        end
      endcase
    end
  end

  // State, datapath and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_phase    <= PhA;
      r_cnt      <= 16'd0;
      r_slot     <= 4'd0;
      r_cmd      <= CmdStart;
      r_tx       <= 8'd0;
      r_rx       <= 8'd0;
      r_nack_cmd <= 1'b0;
      r_illegal  <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_rsp_data <= 8'd0;
      r_rsp_nack <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_scl_hold <= 1'b0;
      r_sda_hold <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_phase    <= w_phase_d;
      r_cnt      <= w_cnt_d;
      r_slot     <= w_slot_d;
      r_scl_hold <= w_scl;
      r_sda_hold <= w_sda;
      if (w_accept) begin
        r_cmd      <= cmd_i;
        r_tx       <= cmd_data_i;
        r_nack_cmd <= cmd_nack_i;
        r_illegal  <= w_illegal;
        if (w_illegal) begin
          r_rsp_err  <= 1'b1;
          r_rsp_nack <= 1'b0;
        end
      end
      if (w_sample) begin
        if (r_slot == 4'd8) r_ack <= sda_i;
        else                r_rx  <= {r_rx[6:0], sda_i};
      end
      if ((r_state == StData) && (r_phase == PhD) && w_phase_end) r_tx <= {r_tx[6:0], 1'b0};
      if (w_finish) begin
        r_rsp_err  <= 1'b0;
        r_rsp_nack <= (r_cmd == CmdWrite) ? w_ack : 1'b0;
        if (r_cmd == CmdRead)  r_rsp_data <= r_rx;
        if (r_cmd == CmdStart) r_busy <= 1'b1;
        if (r_cmd == CmdStop)  r_busy <= 1'b0;
      end
    end
  end

  assign cmd_ready_o = (r_state == StIdle);
  assign rsp_valid_o = (r_state == StDone);
  assign rsp_data_o  = r_rsp_data;
  assign rsp_nack_o  = r_rsp_nack;
  assign rsp_err_o   = r_rsp_err;
  assign busy_o      = r_busy;
  assign scl_oe_o    = w_scl;
  assign sda_oe_o    = w_sda;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Bench for i2c_bit_engine: a cycle-by-cycle expected-waveform queue built from
// the phase tables, an I2C slave model with ACK/data/stretch, and random commands.
module tb_i2c_bit_engine;
  localparam int D = 4;
  localparam logic [1:0] START = 2'b00, STOP = 2'b01, WRITE = 2'b10, READ = 2'b11;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic [1:0] cmd_i = 2'b00;
  logic [7:0] cmd_data_i = 8'h00;
  logic       cmd_nack_i = 1'b0;
  logic       cmd_ready_o, rsp_valid_o, rsp_nack_o, rsp_err_o, busy_o;
  logic [7:0] rsp_data_o;
  logic       scl_i, sda_i, scl_oe_o, sda_oe_o;

  always #5 clk = ~clk;

  i2c_bit_engine #(.CLK_DIV(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_i(cmd_i), .cmd_data_i(cmd_data_i), .cmd_nack_i(cmd_nack_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_nack_o(rsp_nack_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o), .scl_i(scl_i), .sda_i(sda_i),
    .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o)
  );

  typedef struct packed {
    logic       ready;
    logic       valid;
    logic       scl;
    logic       sda;
    logic       busy;
    logic [7:0] data;
    logic       nack;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  logic m_busy = 1'b0, m_scl = 1'b0, m_sda = 1'b0, m_nack = 1'b0, m_err = 1'b0;
  logic [7:0] m_data = 8'h00;
  int   tests = 0, fails = 0;
  bit   chk_en = 1'b0;

  // Slave model configuration, latched at command acceptance
  logic [7:0] drv_rbyte = 8'h00;
  logic       drv_ack = 1'b0;
  int         drv_slot = -1, drv_len = 0;
  logic       s_active = 1'b0, s_ack = 1'b0, s_prev_scl = 1'b0;
  logic [1:0] s_cmd = 2'b00;
  logic [7:0] s_rbyte = 8'h00, wbits = 8'h00;
  int         s_slot = -1, s_rem = 0, fallcnt = 0, wcnt = 0;
  logic       s_hold, s_sda_low;

  assign s_hold    = s_active && (fallcnt == s_slot) && (s_rem > 0);
  assign s_sda_low = s_active && (((s_cmd == READ) && (fallcnt < 8) && !s_rbyte[7 - fallcnt]) ||
                                  ((s_cmd == WRITE) && (fallcnt == 8) && s_ack));
  assign scl_i = ~scl_oe_o & ~s_hold;
  assign sda_i = ~sda_oe_o & ~s_sda_low;

  // Slave: bit index = SCL falls since accept; capture SDA on each SCL rise
  always @(posedge clk) begin
    s_prev_scl <= scl_i;
    if (rst_i) begin
      s_active <= 1'b0; fallcnt <= 0; s_rem <= 0; wbits <= 8'h00; wcnt <= 0;
    end else if (cmd_valid_i && cmd_ready_o) begin
      s_active <= cmd_i[1]; s_cmd <= cmd_i; s_rbyte <= drv_rbyte; s_ack <= drv_ack;
      s_slot <= drv_slot; s_rem <= drv_len; fallcnt <= 0; wbits <= 8'h00; wcnt <= 0;
    end else begin
      if (rsp_valid_o) s_active <= 1'b0;
      if (s_prev_scl && !scl_i) fallcnt <= fallcnt + 1;
      if (s_hold && !scl_oe_o) s_rem <= s_rem - 1;
      if (!s_prev_scl && scl_i && (wcnt < 8)) begin
        wbits <= {wbits[6:0], sda_i};
        wcnt  <= wcnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {scl_oe, sda_oe} for command c, slot s, phase p (0=A..3=D)
  function automatic logic [1:0] exp_lines(input logic [1:0] c, input int s, input int p,
                                           input logic [7:0] d, input logic nk, input logic bsy);
    logic scl, sda;
    if (c == START) begin
      scl = (p == 0) ? bsy : (p == 3);
      sda = (p >= 2);
    end else if (c == STOP) begin
      scl = (p == 0);
      sda = (p <= 1);
    end else begin
      scl = (p == 0) || (p == 3);
      if (s < 8) sda = (c == WRITE) ? ~d[7 - s] : 1'b0;
      else       sda = (c == READ) ? ~nk : 1'b0;
    end
    return {scl, sda};
  endfunction

  function automatic exp_t mk(input logic rdy, input logic vld, input logic [1:0] ln,
                              input logic bsy, input logic [7:0] dat, input logic nk,
                              input logic er);
    exp_t e;
    e.ready = rdy; e.valid = vld; e.scl = ln[1]; e.sda = ln[0];
    e.busy = bsy; e.data = dat; e.nack = nk; e.err = er;
    return e;
  endfunction

  // Per-cycle comparison against the expected waveform (idle model when empty)
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1'b1, 1'b0, {m_scl, m_sda}, m_busy, m_data, m_nack, m_err);
      chk("cmd_ready", 32'(cmd_ready_o), 32'(e.ready));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(e.valid));
      chk("scl_oe",    32'(scl_oe_o),    32'(e.scl));
      chk("sda_oe",    32'(sda_oe_o),    32'(e.sda));
      chk("busy",      32'(busy_o),      32'(e.busy));
      chk("rsp_data",  32'(rsp_data_o),  32'(e.data));
      chk("rsp_nack",  32'(rsp_nack_o),  32'(e.nack));
      chk("rsp_err",   32'(rsp_err_o),   32'(e.err));
    end
  end

  // Present a command for one cycle and queue the expected waveform for it
  task automatic start_cmd(input logic [1:0] c, input logic [7:0] d, input logic nk,
                           input logic [7:0] rb, input logic ack_low,
                           input int st_slot, input int st_len);
    int nslots, n;
    logic [1:0] ln;
    logic nb, nn;
    logic [7:0] nd;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_i = c; cmd_data_i = d; cmd_nack_i = nk;
    drv_rbyte = rb; drv_ack = ack_low; drv_slot = st_slot; drv_len = st_len;
    exp_q.push_back(mk(1'b1, 1'b0, {m_scl, m_sda}, m_busy, m_data, m_nack, m_err));
    if ((c != START) && !m_busy) begin
      exp_q.push_back(mk(1'b0, 1'b1, {m_scl, m_sda}, m_busy, m_data, 1'b0, 1'b1));
      m_nack = 1'b0; m_err = 1'b1;
    end else begin
      nslots = c[1] ? 9 : 1;
      ln = 2'b00;
      for (int s = 0; s < nslots; s++) begin
        for (int p = 0; p < 4; p++) begin
          n = D;
          if ((s == nslots - 1) && (p == 3)) n = D - 1;
          if ((p == 1) && (s == st_slot)) n += st_len;
          ln = exp_lines(c, s, p, d, nk, m_busy);
          repeat (n) exp_q.push_back(mk(1'b0, 1'b0, ln, m_busy, m_data, m_nack, m_err));
        end
      end
      nb = (c == START) ? 1'b1 : (c == STOP) ? 1'b0 : m_busy;
      nn = (c == WRITE) ? ~ack_low : 1'b0;
      nd = (c == READ) ? rb : m_data;
      exp_q.push_back(mk(1'b0, 1'b1, ln, nb, nd, nn, 1'b0));
      m_busy = nb; m_nack = nn; m_data = nd; m_err = 1'b0; m_scl = ln[1]; m_sda = ln[0];
    end
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the engine must ignore them
    cmd_valid_i = 1'b0; cmd_i = 2'($urandom); cmd_data_i = 8'($urandom);
    cmd_nack_i = 1'($urandom);
  endtask

  // Count cycles from acceptance to rsp_valid_o (1 = next cycle)
  task automatic wait_done(output int lat);
    lat = 1;
    while (!rsp_valid_o) begin
      if (lat >= 4000) begin
        tests++; fails++;
        $display("FAIL done_timeout: no rsp_valid after %0d cycles", lat);
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic nk,
                       input logic [7:0] rb, input logic ack_low, input int st_slot,
                       input int st_len, output int lat);
    start_cmd(c, d, nk, rb, ack_low, st_slot, st_len);
    wait_done(lat);
  endtask

  initial begin
    int lat, k, exp_lat, slot, len;
    logic [1:0] c;
    logic [7:0] d, rb;
    logic nk, ack;
    bit ill;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 32'(cmd_ready_o), 32'd1);
    chk("reset_lines", 32'({scl_oe_o, sda_oe_o, busy_o}), 32'd0);

    // WRITE while bus free: error, one cycle, lines untouched
    issue(WRITE, 8'h5A, 1'b0, 8'h00, 1'b0, -1, 0, lat);
    chk("illegal_lat", 32'(lat), 32'd1);
    chk("illegal_err", 32'(rsp_err_o), 32'd1);

    issue(START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat);
    chk("start_lat", 32'(lat), 32'd16);

    issue(WRITE, 8'hA5, 1'b0, 8'h00, 1'b1, -1, 0, lat);
    chk("write_lat", 32'(lat), 32'd144);
    chk("write_bits", 32'(wbits), 32'h0A5);
    chk("write_ack", 32'(rsp_nack_o), 32'd0);

    issue(READ, 8'h00, 1'b1, 8'h3C, 1'b0, -1, 0, lat);
    chk("read_data", 32'(rsp_data_o), 32'h03C);

    issue(WRITE, 8'h96, 1'b0, 8'h00, 1'b0, 3, 20, lat);
    chk("stretch_lat", 32'(lat), 32'd164);
    chk("stretch_bits", 32'(wbits), 32'h096);
    chk("stretch_nack", 32'(rsp_nack_o), 32'd1);

    for (int i = 0; i < 30; i++) begin
      c = 2'($urandom_range(0, 3));
      if (!m_busy && (c != START) && ($urandom_range(0, 3) != 0)) c = START;
      d = 8'($urandom); rb = 8'($urandom); nk = 1'($urandom); ack = 1'($urandom);
      slot = -1; len = 0;
      if (c[1] && ($urandom_range(0, 2) == 0)) begin
        slot = $urandom_range(0, 8); len = $urandom_range(1, 30);
      end
      ill = (c != START) && !m_busy;
      exp_lat = ill ? 1 : (c[1] ? 36 * D + len : 4 * D);
      issue(c, d, nk, rb, ack, slot, len, lat);
      chk("rand_lat", 32'(lat), 32'(exp_lat));
      if (!ill && (c == WRITE)) chk("rand_wbits", 32'(wbits), 32'(d));
      if (!ill && (c == READ))  chk("rand_rdata", 32'(rsp_data_o), 32'(rb));
    end

    // Reset in the middle of a READ (slot 5)
    issue(START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat);
    start_cmd(READ, 8'h00, 1'b0, 8'h5A, 1'b0, -1, 0);
    k = 0;
    while ((fallcnt != 5) && (k < 1000)) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_slot5", 32'(fallcnt), 32'd5);
    repeat (4) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    m_busy = 1'b0; m_scl = 1'b0; m_sda = 1'b0; m_nack = 1'b0; m_err = 1'b0; m_data = 8'h00;
    rst_i = 1'b0;
    chk("rst_oe", 32'({scl_oe_o, sda_oe_o}), 32'd0);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    repeat (200) @(posedge clk);
    #1;

    issue(STOP, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat);
    chk("stop_idle_lat", 32'(lat), 32'd1);
    issue(START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat);
    issue(STOP, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0, lat);
    chk("stop_lat", 32'(lat), 32'd16);
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_bit_engine.md
I2C_BIT_ENGINE -- requirements
Module: i2c_bit_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving clk_i cycles per quarter-bit phase; legal range 1..65535.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid_i  input  1  command present.
REQ-005 SHALL have port cmd_ready_o  output  1  engine accepts a command this cycle.
REQ-006 SHALL have port cmd_i  input  2  00=START, 01=STOP, 10=WRITE, 11=READ.
REQ-007 SHALL have port cmd_data_i  input  8  WRITE byte, sent MSB first.
REQ-008 SHALL have port cmd_nack_i  input  1  READ only: 1 = send NACK, 0 = send ACK.
REQ-009 SHALL have port rsp_valid_o  output  1  one-cycle pulse when a command completes.
REQ-010 SHALL have port rsp_data_o  output  8  READ byte, held until the next READ completes.
REQ-011 SHALL have port rsp_nack_o  output  1  WRITE: sampled ACK bit (1 = NACK).
REQ-012 SHALL have port rsp_err_o  output  1  command illegal for the current bus state.
REQ-013 SHALL have port busy_o  output  1  bus owned (set after START, cleared after STOP).
REQ-014 SHALL have ports scl_i, sda_i  input  1 each  sampled bus lines.
REQ-015 SHALL have ports scl_oe_o, sda_oe_o  output  1 each  1 = pull line low; 0 = release.

Function
REQ-016 SHALL use one 4-phase bit slot A,B,C,D, each CLK_DIV cycles; phase B counting starts only once scl_i is sampled high (clock stretching).
REQ-017 SHALL assert cmd_ready_o only in IDLE; accept on cmd_valid_i & cmd_ready_o; deassert cmd_ready_o the next cycle.
REQ-018 SHALL implement states IDLE, START, STOP, DATA (9 slots), DONE; DONE lasts one cycle, pulses rsp_valid_o, then returns to IDLE with cmd_ready_o = 1.
REQ-019 SHALL run START (legal in any state, repeated start included) as A: SCL held low only if busy_o, SDA released; B: SCL released; C: SDA low; D: SCL low; then busy_o = 1.
REQ-020 SHALL run STOP as A: SCL low, SDA low; B: SCL released; C: SDA released; D: both released; then busy_o = 0.
REQ-021 SHALL run WRITE as 8 slots driving cmd_data_i[7..0] in phase A (sda_oe_o = ~bit), plus a 9th slot with SDA released.
REQ-022 SHALL run READ as 8 slots with SDA released, plus a 9th slot with sda_oe_o = ~cmd_nack_i.
REQ-023 SHALL sample sda_i in the last cycle of phase C of each slot; READ bits shift in MSB first; WRITE slot 9 sample goes to rsp_nack_o.
REQ-024 SHALL hold scl_oe_o = 1 in phases A and D and 0 in phases B and C of every data slot.
REQ-025 SHALL register cmd_data_i and cmd_nack_i at acceptance; later input changes SHALL have no effect.
REQ-026 SHALL treat WRITE, READ or STOP with busy_o = 0 as illegal: no bus activity, DONE on the following cycle with rsp_err_o = 1.
REQ-027 SHALL drive rsp_err_o = 0 on every legal completion; rsp_nack_o SHALL be 0 after START, STOP or READ.
REQ-028 SHALL time legal commands without stretching at exactly 4*CLK_DIV (START/STOP) or 36*CLK_DIV (WRITE/READ) cycles from acceptance to DONE.
REQ-029 SHALL wait indefinitely in phase B while scl_i stays low; no timeout.

Reset
REQ-030 SHALL, on rst_i = 1 at a clock edge, enter IDLE and set scl_oe_o = 0, sda_oe_o = 0, cmd_ready_o = 1, rsp_valid_o = 0, rsp_data_o = 0, rsp_nack_o = 0, rsp_err_o = 0, busy_o = 0, and clear all counters.
REQ-031 SHALL, on reset mid-command, release both lines at that edge and produce no rsp_valid_o for the aborted command.

Verification
REQ-032 SHALL cover: CLK_DIV=4, START from idle -> SDA falls while SCL high, SCL low 4 cycles later, rsp_valid_o 16 cycles after accept, busy_o = 1.
REQ-033 SHALL cover: WRITE 0xA5, slave ACK (sda_i low in slot 9) -> SDA bit sequence 1,0,1,0,0,1,0,1, rsp_nack_o = 0, DONE 144 cycles after accept.
REQ-034 SHALL cover: READ, slave drives 0x3C, cmd_nack_i = 1 -> rsp_data_o = 0x3C, SDA released in slot 9.
REQ-035 SHALL cover: WRITE with busy_o = 0 -> no line change, rsp_valid_o with rsp_err_o = 1 one cycle after accept.
REQ-036 SHALL cover: slave holds scl_i low 20 cycles in slot 3 phase B -> DONE delayed by exactly 20 cycles, data intact.
REQ-037 SHALL cover: rst_i during READ slot 5 -> both oe outputs 0 after that edge, no rsp_valid_o, cmd_ready_o = 1, busy_o = 0.
